// File: rtl/score_render_pkg.sv
// score_render_pkg: shared FSM state, BCD nibble type and decimal power helper
package score_render_pkg;
   typedef enum logic [1:0] {IDLE, CONV, PEND} state_t;
   typedef logic [3:0] bcd_t;
   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction
endpackage

// File: rtl/score_glyph_rom.sv
// score_glyph_rom: 10-glyph seven-segment bitmap ROM, synchronous read with one-cycle latency
module score_glyph_rom #(
   parameter int DIGIT_W = 60,
   parameter int DIGIT_H = 60,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output logic          data
);
   localparam int T = DIGIT_H / 10 > 0 ? DIGIT_H / 10 : 1;
   localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   function automatic logic glyph_bit(input int a);
      int g, r, c;
      logic [6:0] s;
      g = a / (DIGIT_W * DIGIT_H);
      r = (a % (DIGIT_W * DIGIT_H)) / DIGIT_W;
      c = a % DIGIT_W;
      s = {r >= DIGIT_H / 2 - T / 2 && r < DIGIT_H / 2 - T / 2 + T,
           c < T && r < DIGIT_H / 2,
           c < T && r >= DIGIT_H / 2,
           r >= DIGIT_H - T,
           c >= DIGIT_W - T && r >= DIGIT_H / 2,
           c >= DIGIT_W - T && r < DIGIT_H / 2,
           r < T};
      return g < 10 ? |(SEG[4'(g)] & s) : 1'b0;
   endfunction
   always_ff @(posedge clk) data <= glyph_bit(int'(addr));
endmodule

// File: rtl/score_render.sv
// score_render: binary score to BCD via double-dabble, frame-synchronous commit, pipelined digit-strip pixel renderer
module score_render
   import score_render_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W = 16,
   parameter int DIGIT_W = 60,
   parameter int DIGIT_H = 60,
   parameter int X0 = 40,
   parameter int Y0 = 360,
   parameter int LZ_BLANK = 1,
   parameter int COMMIT_ON_FRAME = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] score,
   input  logic             score_valid,
   output logic             score_ready,
   input  logic             frame_start,
   input  logic [10:0]      col_addr_sig,
   input  logic [10:0]      row_addr_sig,
   output logic             pixel_on,
   output logic             in_region,
   output logic             overflow
);
   localparam int DW = NUM_DIGITS * 4;
   localparam longint MAXV = pow10(NUM_DIGITS) - 1;
   localparam int AW = $clog2(10 * DIGIT_W * DIGIT_H);
   localparam int CW = $clog2(BIN_W + 1);
   state_t state, state_nx;
   logic [BIN_W-1:0] bin, score_sat;
   logic [DW-1:0] bcd, bcd_adj, disp;
   logic [CW-1:0] cnt;
   logic ovf_p, disp_ovf, capture, commit, sat;
   int rc, rr, idx;
   logic z, hit, blank, s1_hit, s1_blank, s2_hit, s2_blank, rom_bit;
   logic [NUM_DIGITS-1:0] lz;
   bcd_t glyph, nib;
   logic [AW-1:0] addr_c, s1_addr;
   assign score_ready = state == IDLE && !rst;
   assign capture = score_valid && score_ready;
   assign commit = state == PEND && (COMMIT_ON_FRAME == 0 || frame_start);
   assign sat = 64'(score) > 64'(MAXV);
   assign score_sat = sat ? BIN_W'(MAXV) : score;
   assign state_nx = state == IDLE ? (capture ? CONV : IDLE) :
                     state == CONV ? (cnt == CW'(BIN_W - 1) ? PEND : CONV) :
                     (commit ? IDLE : PEND);
   always_comb begin
      bcd_adj = bcd;
      nib = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib = bcd[i*4 +: 4];
         bcd_adj[i*4 +: 4] = nib >= 4'd5 ? nib + 4'd3 : nib;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bin <= '0;
         bcd <= '0;
         cnt <= '0;
         ovf_p <= 1'b0;
         disp <= '0;
         disp_ovf <= 1'b0;
      end else begin
         state <= state_nx;
         if (capture) begin
            bin <= score_sat;
            bcd <= '0;
            cnt <= '0;
            ovf_p <= sat;
         end else if (state == CONV) begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
            cnt <= cnt + CW'(1);
         end
         if (commit) begin
            disp <= bcd;
            disp_ovf <= ovf_p;
         end
      end
   end
   // lz[k] is set when digit k and every digit to its left are zero
   always_comb begin
      rc = int'(col_addr_sig) - X0;
      rr = int'(row_addr_sig) - Y0;
      hit = 1'b0;
      idx = 0;
      z = 1'b1;
      lz = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         z = z && disp[(NUM_DIGITS-1-k)*4 +: 4] == 4'd0;
         lz[k] = z;
         if (rr >= 0 && rr < DIGIT_H && rc >= k * DIGIT_W && rc < (k + 1) * DIGIT_W) begin
            hit = 1'b1;
            idx = k;
         end
      end
      glyph = disp[(NUM_DIGITS-1-idx)*4 +: 4];
      blank = LZ_BLANK != 0 && idx != NUM_DIGITS - 1 && lz[idx];
      addr_c = AW'(int'(glyph) * DIGIT_W * DIGIT_H + rr * DIGIT_W + rc - idx * DIGIT_W);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_hit <= 1'b0;
         s1_blank <= 1'b0;
         s1_addr <= '0;
         s2_hit <= 1'b0;
         s2_blank <= 1'b0;
      end else begin
         s1_hit <= hit;
         s1_blank <= blank;
         s1_addr <= addr_c;
         s2_hit <= s1_hit;
         s2_blank <= s1_blank;
      end
   end
   score_glyph_rom #(.DIGIT_W(DIGIT_W), .DIGIT_H(DIGIT_H), .AW(AW)) u_rom (
      .clk (clk),
      .addr(s1_addr),
      .data(rom_bit)
   );
   assign pixel_on = rom_bit && s2_hit && !s2_blank;
   assign in_region = s2_hit;
   assign overflow = disp_ovf;
endmodule

// File: tb/tb_score_render.sv
// tb_score_render: randomized checks of score_render against a seven-segment display reference model
module tb_score_render;
   logic clk = 0, rst = 1, score_valid = 0, frame_start = 0;
   logic [15:0] score = 0;
   logic [10:0] col = 0, row = 0;
   logic score_ready, pixel_on, in_region, overflow;
   int tests = 0, fails = 0, cur_val = 0;
   bit cur_ovf = 0;
   string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
   int bc [12] = '{40, 39, 279, 280, 99, 100, 70, 50, 160, 160, 159, 220};
   int br [12] = '{360, 360, 419, 419, 380, 380, 390, 370, 359, 420, 400, 390};
   int p10 [4] = '{1000, 100, 10, 1};

   score_render dut (
      .clk(clk), .rst(rst), .score(score), .score_valid(score_valid), .score_ready(score_ready),
      .frame_start(frame_start), .col_addr_sig(col), .row_addr_sig(row),
      .pixel_on(pixel_on), .in_region(in_region), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [1:0] model_px(input int c, input int r, input int val);
      int k, x, y, d;
      bit lit, blank;
      if (c < 40 || c >= 280 || r < 360 || r >= 420) return 2'b00;
      k = (c - 40) / 60;
      x = (c - 40) % 60;
      y = r - 360;
      d = (val / p10[k]) % 10;
      blank = k < 3 && val < p10[k];
      lit = 0;
      for (int i = 0; i < segs[d].len(); i++)
         case (segs[d][i])
            "a": lit |= y < 6;
            "b": lit |= x >= 54 && y < 30;
            "c": lit |= x >= 54 && y >= 30;
            "d": lit |= y >= 54;
            "e": lit |= x < 6 && y >= 30;
            "f": lit |= x < 6 && y < 30;
            "g": lit |= y >= 27 && y < 33;
            default: ;
         endcase
      return {1'b1, lit && !blank};
   endfunction

   task automatic stream(input int n, input int val, input bit ovf);
      int qc[$], qr[$];
      int c, r;
      logic [1:0] e;
      tests++;
      if (overflow !== ovf) begin
         fails++;
         $display("FAIL overflow got %b want %b", overflow, ovf);
      end
      for (int i = 0; i < n + 2; i++) begin
         if (i >= 2) begin
            c = qc.pop_front();
            r = qr.pop_front();
            e = model_px(c, r, val);
            tests += 2;
            if (in_region !== e[1]) begin
               fails++;
               $display("FAIL in_region (%0d,%0d) val %0d got %b want %b", c, r, val, in_region, e[1]);
            end
            if (pixel_on !== e[0]) begin
               fails++;
               $display("FAIL pixel_on (%0d,%0d) val %0d got %b want %b", c, r, val, pixel_on, e[0]);
            end
         end
         if (i < n) begin
            c = i < 12 ? bc[i] : int'($urandom_range(20, 300));
            r = i < 12 ? br[i] : int'($urandom_range(340, 440));
            col = 11'(c);
            row = 11'(r);
            qc.push_back(c);
            qr.push_back(r);
         end
         @(negedge clk);
      end
   endtask

   task automatic start(input int v);
      int n = 0;
      while (!score_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (score_ready !== 1'b1) begin
         fails++;
         $display("FAIL start_ready got %b want 1", score_ready);
      end
      score = 16'(v);
      score_valid = 1;
      @(negedge clk);
      score_valid = 0;
   endtask

   task automatic commit_frame();
      frame_start = 1;
      @(negedge clk);
      frame_start = 0;
   endtask

   task automatic load(input int v);
      start(v);
      repeat (16) @(negedge clk);
      commit_frame();
      cur_val = v > 9999 ? 9999 : v;
      cur_ovf = v > 9999;
   endtask

   task automatic test_reset();
      rst = 1;
      @(negedge clk);
      tests++;
      if (score_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready got %b want 0", score_ready);
      end
      @(negedge clk);
      tests += 3;
      if (in_region !== 1'b0) begin
         fails++;
         $display("FAIL reset_in_region got %b want 0", in_region);
      end
      if (pixel_on !== 1'b0) begin
         fails++;
         $display("FAIL reset_pixel_on got %b want 0", pixel_on);
      end
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_overflow got %b want 0", overflow);
      end
      rst = 0;
      #1;
      tests++;
      if (score_ready !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_ready got %b want 1", score_ready);
      end
      @(negedge clk);
      stream(16, 0, 0);
   endtask

   task automatic test_basic();
      load(1234);
      stream(60, cur_val, cur_ovf);
   endtask

   task automatic test_blank();
      load(7);
      stream(40, cur_val, cur_ovf);
      load(0);
      stream(40, cur_val, cur_ovf);
   endtask

   task automatic test_overflow();
      load(12345);
      stream(40, cur_val, cur_ovf);
      load(5);
      stream(30, cur_val, cur_ovf);
   endtask

   task automatic test_hold_valid();
      start(4321);
      score = 16'd8765;
      score_valid = 1;
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (score_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_ready cycle %0d got %b want 0", i, score_ready);
         end
         @(negedge clk);
      end
      score_valid = 0;
      commit_frame();
      cur_val = 4321;
      cur_ovf = 0;
      stream(40, cur_val, cur_ovf);
   endtask

   task automatic test_frame_race();
      start(2468);
      repeat (15) @(negedge clk);
      commit_frame();
      tests++;
      if (score_ready !== 1'b0) begin
         fails++;
         $display("FAIL race_pending_ready got %b want 0", score_ready);
      end
      stream(20, cur_val, cur_ovf);
      commit_frame();
      cur_val = 2468;
      cur_ovf = 0;
      stream(30, cur_val, cur_ovf);
   endtask

   task automatic test_reset_mid();
      load(12000);
      start(9876);
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      tests++;
      if (score_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset_ready got %b want 1", score_ready);
      end
      @(negedge clk);
      cur_val = 0;
      cur_ovf = 0;
      stream(20, cur_val, cur_ovf);
      repeat (20) @(negedge clk);
      commit_frame();
      stream(12, cur_val, cur_ovf);
   endtask

   task automatic test_random();
      int v;
      for (int n = 0; n < 8; n++) begin
         v = n % 3 == 0 ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
         load(v);
         stream(40, cur_val, cur_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blank();
      test_overflow();
      test_hold_valid();
      test_frame_race();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
